// File: rtl/se_fc_accumulator.sv
// se_fc_accumulator: bias-seeded Q5.9 dot-product accumulator that feeds the relu stage.
// Optional macro ACC_SAT_EN: every accumulator add saturates instead of wrapping.
module se_fc_accumulator #(
  parameter int INT_BITS   = 5,
  parameter int FRAC_BITS  = 9,
  parameter int DATA_WIDTH = INT_BITS + FRAC_BITS,
  parameter int ACC_WIDTH  = DATA_WIDTH*2 - FRAC_BITS + 6,
  parameter int IN_CH      = 16,
  parameter int OUT_CH     = 4,
  localparam int NIDX_W    = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] act_in,
  input  logic signed [DATA_WIDTH-1:0] wgt_in,
  input  logic signed [DATA_WIDTH-1:0] bias_in,
  output logic signed [ACC_WIDTH-1:0]  acc_out,
  output logic                         acc_valid,
  output logic [NIDX_W-1:0]            neuron_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int EXT_W  = (PROD_W > ACC_WIDTH) ? PROD_W : ACC_WIDTH;
  localparam int BEAT_W = $clog2(IN_CH);
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(IN_CH - 1);
  localparam logic [NIDX_W-1:0] LAST_NEURON = NIDX_W'(OUT_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

  state_e                       state_q, state_d;
  logic [BEAT_W-1:0]            beat_cnt_q, beat_cnt_d;
  logic [NIDX_W-1:0]            neuron_idx_q, neuron_idx_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]  acc_out_q, acc_out_d;
  logic                         acc_valid_q, acc_valid_d;
  logic                         done_q, done_d;

  logic signed [PROD_W-1:0]     prod;
  logic signed [EXT_W-1:0]      prod_ext;
  logic signed [ACC_WIDTH-1:0]  prod_s;
  logic signed [ACC_WIDTH-1:0]  add_base;
  logic signed [ACC_WIDTH-1:0]  acc_sum;

  // Accumulator add: clamps to the ACC_WIDTH range when saturation is built in,
  // otherwise plain two's-complement wrap.
  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
`ifdef ACC_SAT_EN
    logic signed [ACC_WIDTH:0] s;
    s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
      acc_add = s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      acc_add = s[ACC_WIDTH-1:0];
    end
`else
    acc_add = a + b;
`endif
  endfunction

  // Product stage: full-precision Q10.18 product, floored back to Q.9.
  always_comb begin
    prod     = PROD_W'(act_in) * PROD_W'(wgt_in);
    prod_ext = EXT_W'(prod) >>> FRAC_BITS;
    prod_s   = ACC_WIDTH'(prod_ext);
    add_base = (beat_cnt_q == '0) ? ACC_WIDTH'(bias_in) : acc_q;
    acc_sum  = acc_add(add_base, prod_s);
  end

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    neuron_idx_d = neuron_idx_q;
    acc_d        = acc_q;
    acc_out_d    = acc_out_q;
    acc_valid_d  = 1'b0;
    done_d       = 1'b0;
    in_ready     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          beat_cnt_d   = '0;
          neuron_idx_d = '0;
          state_d      = S_ACC;
        end
      end

      S_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d = acc_sum;
          if (beat_cnt_q == LAST_BEAT) begin
            // acc_valid/done are registered so they are high exactly while in OUT
            beat_cnt_d  = '0;
            acc_out_d   = acc_sum;
            acc_valid_d = 1'b1;
            done_d      = (neuron_idx_q == LAST_NEURON);
            state_d     = S_OUT;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end

      S_OUT: begin
        if (neuron_idx_q == LAST_NEURON) begin
          state_d = S_IDLE;
        end else begin
          neuron_idx_d = neuron_idx_q + 1'b1;
          beat_cnt_d   = '0;
          state_d      = S_ACC;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      beat_cnt_q   <= '0;
      neuron_idx_q <= '0;
      acc_q        <= '0;
      acc_out_q    <= '0;
      acc_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      neuron_idx_q <= neuron_idx_d;
      acc_q        <= acc_d;
      acc_out_q    <= acc_out_d;
      acc_valid_q  <= acc_valid_d;
      done_q       <= done_d;
    end
  end

  assign acc_out    = acc_out_q;
  assign acc_valid  = acc_valid_q;
  assign neuron_idx = neuron_idx_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_se_fc_accumulator.sv
// Self-checking bench for se_fc_accumulator: constant vector table, randomized jobs
// against a plain-arithmetic reference model, reset abort and a wide saturation instance.
`timescale 1ns/1ps
module tb_se_fc_accumulator;

  localparam int DW     = 14;
  localparam int AW     = 25;
  localparam int IN_CH  = 16;
  localparam int OUT_CH = 4;
  localparam int BIG_IN = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0, start_b = 1'b0, in_valid = 1'b0;
  logic signed [DW-1:0] act = '0, wgt = '0, bias = '0;

  logic in_ready, acc_valid, busy, done;
  logic signed [AW-1:0] acc_out;
  logic [1:0] neuron_idx;
  logic in_ready_b, acc_valid_b, busy_b, done_b;
  logic signed [AW-1:0] acc_out_b;
  logic [0:0] neuron_idx_b;

  always #5 clk = ~clk;

  se_fc_accumulator #(.IN_CH(IN_CH), .OUT_CH(OUT_CH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .act_in(act), .wgt_in(wgt), .bias_in(bias), .acc_out(acc_out), .acc_valid(acc_valid),
    .neuron_idx(neuron_idx), .busy(busy), .done(done));

  se_fc_accumulator #(.IN_CH(BIG_IN), .OUT_CH(1)) dut_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .in_valid(in_valid), .in_ready(in_ready_b),
    .act_in(act), .wgt_in(wgt), .bias_in(bias), .acc_out(acc_out_b), .acc_valid(acc_valid_b),
    .neuron_idx(neuron_idx_b), .busy(busy_b), .done(done_b));

  int n_vec = 0, n_bad = 0;
  int cyc = 0;
  int stray_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint acc; int idx; bit dn; int cyc; } obs_t;
  obs_t obs_q[$];

  always @(negedge clk) begin
    if (acc_valid) obs_q.push_back('{longint'(acc_out), int'(neuron_idx), done, cyc});
    if (done && !acc_valid) stray_done++;
  end

  typedef struct { int a; int w; int b; longint exp; } vec_t;
  vec_t tbl[6];

  int     j_act[OUT_CH][IN_CH];
  int     j_wgt[OUT_CH][IN_CH];
  int     j_bias[OUT_CH];
  longint j_exp[OUT_CH];
  int     last_edge[OUT_CH];
  int     m_act[BIG_IN];
  int     m_wgt[BIG_IN];

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic abort_run(input string why);
    n_bad++;
    $display("FAIL %s: bound expired", why);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1);
  endtask

  // Reference: bias plus sum of floor(a*w / 2^9); clamp per add or wrap mod 2^AW.
  function automatic longint model(input int n, input longint b0);
    longint s, p, lim;
    lim = longint'(1) <<< (AW - 1);
    s = b0;
    for (int i = 0; i < n; i++) begin
      p = longint'(m_act[i]) * longint'(m_wgt[i]);
      s = s + (p >>> 9);
`ifdef ACC_SAT_EN
      if (s > lim - 1) s = lim - 1;
      else if (s < -lim) s = -lim;
`endif
    end
`ifndef ACC_SAT_EN
    s = s & ((lim <<< 1) - 1);
    if (s >= lim) s = s - (lim <<< 1);
`endif
    return s;
  endfunction

  // Runs one job on the main instance. stop_after >= 0 returns after that many
  // accepted beats (used for the reset abort) without checking results.
  task automatic run_job(input int gap_pct, input bit extra_start, input string tag,
                         input int stop_after);
    bit took;
    int guard, taken;
    obs_q.delete();
    taken = 0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1;
    act = 14'h1FFF; wgt = 14'h1FFF; bias = 14'h1FFF;
    check($sformatf("%s in_ready idle", tag), in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s busy", tag), busy, 1);
    for (int n = 0; n < OUT_CH; n++) begin
      for (int b = 0; b < IN_CH; b++) begin
        if (stop_after >= 0 && taken == stop_after) return;
        took = 1'b0;
        guard = 0;
        while (!took) begin
          in_valid = ($urandom_range(99) >= gap_pct);
          act  = DW'(j_act[n][b]);
          wgt  = DW'(j_wgt[n][b]);
          bias = (b == 0) ? DW'(j_bias[n]) : DW'($urandom);
          start = extra_start && (n == 1) && (b == 3);
          took = in_valid && in_ready;
          if (took && b == IN_CH - 1) last_edge[n] = cyc + 1;
          @(negedge clk);
          guard++;
          if (guard > 60) abort_run($sformatf("%s beat wait", tag));
        end
        taken++;
      end
    end
    in_valid = 1'b0;
    start = 1'b0;
    guard = 0;
    while (busy || obs_q.size() < OUT_CH) begin
      @(negedge clk);
      guard++;
      if (guard > 20) abort_run($sformatf("%s result wait", tag));
    end
    repeat (3) @(negedge clk);
    check($sformatf("%s pulse count", tag), obs_q.size(), OUT_CH);
    for (int i = 0; i < OUT_CH && i < obs_q.size(); i++) begin
      check($sformatf("%s acc[%0d]", tag, i), obs_q[i].acc, j_exp[i]);
      check($sformatf("%s idx[%0d]", tag, i), obs_q[i].idx, i);
      check($sformatf("%s done[%0d]", tag, i), obs_q[i].dn, (i == OUT_CH - 1));
      check($sformatf("%s latency[%0d]", tag, i), obs_q[i].cyc, last_edge[i]);
    end
    check($sformatf("%s busy after", tag), busy, 0);
    check($sformatf("%s acc_out held", tag), acc_out, j_exp[OUT_CH-1]);
  endtask

  task automatic fill_const(input int a, input int w, input int b, input longint e);
    for (int n = 0; n < OUT_CH; n++) begin
      for (int k = 0; k < IN_CH; k++) begin
        j_act[n][k] = a;
        j_wgt[n][k] = w;
      end
      j_bias[n] = b;
      j_exp[n] = e;
    end
  endtask

  task automatic run_big(input string tag, input longint exp);
    int guard;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    for (int k = 0; k < BIG_IN; k++) begin
      in_valid = 1'b1;
      act = DW'(m_act[k]);
      wgt = DW'(m_wgt[k]);
      bias = DW'(8191);
      guard = 0;
      while (!in_ready_b) begin
        @(negedge clk);
        guard++;
        if (guard > 10) abort_run($sformatf("%s beat wait", tag));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    guard = 0;
    while (!acc_valid_b) begin
      @(negedge clk);
      guard++;
      if (guard > 10) abort_run($sformatf("%s result wait", tag));
    end
    check($sformatf("%s acc", tag), acc_out_b, exp);
    check($sformatf("%s done", tag), done_b, 1);
    @(negedge clk);
    check($sformatf("%s busy after", tag), busy_b, 0);
  endtask

  initial begin
    #1_000_000;
    abort_run("global watchdog");
  end

  initial begin
    longint big_exp;
    tbl[0] = '{512, 512, 0, 8192};
    tbl[1] = '{-512, 256, 128, -3968};
    tbl[2] = '{1, 1, 0, 0};
    tbl[3] = '{1, -1, 0, -16};
    tbl[4] = '{768, 768, 512, 18944};
    tbl[5] = '{8191, -8192, -8192, -2105088};

    repeat (2) @(negedge clk);
    check("reset acc_out", acc_out, 0);
    check("reset acc_valid", acc_valid, 0);
    check("reset in_ready", in_ready, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset neuron_idx", neuron_idx, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      fill_const(tbl[i].a, tbl[i].w, tbl[i].b, tbl[i].exp);
      run_job((i == 4) ? 25 : 0, 1'b0, $sformatf("table%0d", i), -1);
    end

    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < OUT_CH; n++) begin
        for (int k = 0; k < IN_CH; k++) begin
          j_act[n][k] = int'($urandom_range(16383)) - 8192;
          j_wgt[n][k] = int'($urandom_range(16383)) - 8192;
          m_act[k] = j_act[n][k];
          m_wgt[k] = j_wgt[n][k];
        end
        j_bias[n] = int'($urandom_range(16383)) - 8192;
        j_exp[n] = model(IN_CH, longint'(j_bias[n]));
      end
      run_job(30, (r == 0), $sformatf("rand%0d", r), -1);
    end

    // beats offered while idle are not accepted and produce nothing
    obs_q.delete();
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle in_ready", in_ready, 0);
    in_valid = 1'b0;
    check("idle no pulse", obs_q.size(), 0);

    // Reset at beat 7 of neuron 1
    fill_const(512, 512, 0, 8192);
    run_job(0, 1'b0, "abort", IN_CH + 7);
    in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("abort acc_out", acc_out, 0);
    check("abort in_ready", in_ready, 0);
    check("abort busy", busy, 0);
    check("abort neuron_idx", neuron_idx, 0);
    check("abort acc_valid", acc_valid, 0);
    check("abort done", done, 0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort pulse count", obs_q.size(), 1);
    rst_n = 1'b1;
    run_job(0, 1'b0, "post-reset unity", -1);

    for (int k = 0; k < BIG_IN; k++) begin
      m_act[k] = 8191;
      m_wgt[k] = 8191;
    end
`ifdef ACC_SAT_EN
    big_exp = 16777215;
`else
    big_exp = -16773121;
`endif
    run_big("sat-corner", big_exp);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < BIG_IN; k++) begin
        m_act[k] = 8191 - int'($urandom_range(40));
        m_wgt[k] = (k % 9 == 0) ? -int'($urandom_range(8192)) : 8191 - int'($urandom_range(40));
      end
      run_big($sformatf("big-rand%0d", r), model(BIG_IN, 64'sd8191));
    end

    check("stray done", stray_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
